// File: rtl/rat_pkg.sv
// Shared types and helpers for the parametrised rat maze solver.
// Positions use a fixed 16-bit signed-free encoding; a step off row/col 0 wraps high and reads as off-grid.
package rat_pkg;

  typedef enum logic [1:0] {UP = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, LEFT = 2'b11} dir_t;

  typedef enum logic [3:0] {
    IDLE, INIT, PROBE, WAIT, DECIDE, BACK, DONE, FAIL, REPLAY
  } state_t;

  localparam int PW = 16;

  typedef struct packed {
    logic [PW-1:0] row;
    logic [PW-1:0] col;
  } pos_t;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  function automatic pos_t step(input logic [PW-1:0] row, input logic [PW-1:0] col, input dir_t d);
    pos_t p;
    p.row = row;
    p.col = col;
    case (d)
      UP:      p.row = row - 16'd1;
      RIGHT:   p.col = col + 16'd1;
      DOWN:    p.row = row + 16'd1;
      default: p.col = col - 16'd1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rat_path_stack.sv
// Path LIFO: push/pop with stack pointer, plus an indexed read port used for bottom-first replay.
module rat_path_stack #(
  parameter int DEPTH = 256,
  parameter int W     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 top,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty,
  input  logic [$clog2(DEPTH+1)-1:0]   rd_idx,
  output logic [W-1:0]                 rd_data
);
  localparam int SPW = $clog2(DEPTH+1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] ONE = SPW'(1);

  logic [W-1:0] mem [DEPTH];

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign top     = mem[IW'(sp - ONE)];
  assign rd_data = mem[IW'(rd_idx)];

  always_ff @(posedge clk) begin
    if (rst || clr)          sp <= '0;
    else if (push && !full)  sp <= sp + ONE;
    else if (pop && !empty)  sp <= sp - ONE;
  end

  // Contents survive clr so a found path stays replayable until the next push.
  always_ff @(posedge clk) begin
    if (push && !full) mem[IW'(sp)] <= din;
  end

endmodule

// File: rtl/rat_maze_solver_param.sv
// Depth-first maze search against a 1-cycle wall ROM; the path is kept on a LIFO and replayed one move per cycle.
module rat_maze_solver_param
  import rat_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(ROWS*COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         run,
  input  logic [$clog2(ROWS)-1:0]      start_row,
  input  logic [$clog2(COLS)-1:0]      start_col,
  input  logic [$clog2(ROWS)-1:0]      goal_row,
  input  logic [$clog2(COLS)-1:0]      goal_col,
  output logic [AW-1:0]                mem_addr,
  output logic                         mem_rd,
  input  logic                         mem_wall,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic [1:0]                   move,
  output logic                         move_valid,
  output logic [$clog2(DEPTH+1)-1:0]   path_len
);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int SPW = $clog2(DEPTH+1);
  localparam logic [SPW-1:0] ONE = SPW'(1);

  state_t state, state_nx;
  logic [RW-1:0] row, goal_r;
  logic [CW-1:0] col, goal_c;
  dir_t dir;
  logic [ROWS*COLS-1:0] visited;
  logic wall_q;
  logic [SPW-1:0] sp, ridx;
  logic full, empty, push, pop, clr;
  logic [1:0] top_d, rd_d;
  pos_t nb, pb;
  logic off, seen, at_goal, skip;
  logic [AW-1:0] naddr, caddr;

  // Neighbour in the current probe direction and the cell we would return to on a pop.
  assign nb      = step(16'(row), 16'(col), dir);
  assign pb      = step(16'(row), 16'(col), opposite(dir_t'(top_d)));
  assign off     = (nb.row >= 16'(ROWS)) || (nb.col >= 16'(COLS));
  assign naddr   = AW'(32'(nb.row) * 32'(COLS) + 32'(nb.col));
  assign caddr   = AW'(32'(row) * 32'(COLS) + 32'(col));
  assign seen    = visited[naddr];
  assign skip    = off || seen;
  assign at_goal = (nb.row == 16'(goal_r)) && (nb.col == 16'(goal_c));

  rat_path_stack #(.DEPTH(DEPTH), .W(2)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .push   (push),
    .pop    (pop),
    .din    (dir),
    .top    (top_d),
    .sp     (sp),
    .full   (full),
    .empty  (empty),
    .rd_idx (ridx),
    .rd_data(rd_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    push       = 1'b0;
    pop        = 1'b0;
    clr        = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    move       = 2'b00;
    move_valid = 1'b0;
    case (state)
      IDLE, FAIL: if (start) state_nx = INIT;
      INIT: begin
        clr      = 1'b1;
        state_nx = (row == goal_r && col == goal_c) ? DONE : PROBE;
      end
      PROBE: begin
        if (skip) begin
          state_nx = (dir == LEFT) ? BACK : PROBE;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = naddr;
          state_nx = WAIT;
        end
      end
      WAIT: state_nx = DECIDE;
      DECIDE: begin
        if (!wall_q) begin
          if (full) begin
            state_nx = FAIL;
          end else begin
            push     = 1'b1;
            state_nx = at_goal ? DONE : PROBE;
          end
        end else begin
          state_nx = (dir == LEFT) ? BACK : PROBE;
        end
      end
      BACK: begin
        if (empty) begin
          state_nx = FAIL;
        end else begin
          pop      = 1'b1;
          state_nx = (top_d == LEFT) ? BACK : PROBE;
        end
      end
      DONE: begin
        if (start)              state_nx = INIT;
        else if (run && !empty) state_nx = REPLAY;
      end
      REPLAY: begin
        move_valid = 1'b1;
        move       = rd_d;
        if (ridx == sp - ONE) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      goal_r  <= '0;
      goal_c  <= '0;
      dir     <= UP;
      visited <= '0;
      wall_q  <= 1'b0;
      ridx    <= '0;
    end else begin
      ridx <= '0;
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            row    <= start_row;
            col    <= start_col;
            goal_r <= goal_row;
            goal_c <= goal_col;
          end
        end
        INIT: begin
          visited        <= '0;
          visited[caddr] <= 1'b1;
          dir            <= UP;
        end
        PROBE: if (skip && dir != LEFT) dir <= dir_t'(dir + 2'd1);
        WAIT:  wall_q <= mem_wall;
        DECIDE: begin
          if (!wall_q) begin
            if (!full) begin
              row            <= RW'(nb.row);
              col            <= CW'(nb.col);
              visited[naddr] <= 1'b1;
              dir            <= UP;
            end
          end else if (dir != LEFT) begin
            dir <= dir_t'(dir + 2'd1);
          end
        end
        BACK: begin
          // A popped LEFT wraps dir to UP, but BACK pops again so it is never used.
          if (!empty) begin
            row <= RW'(pb.row);
            col <= CW'(pb.col);
            dir <= dir_t'(top_d + 2'd1);
          end
        end
        REPLAY: ridx <= ridx + ONE;
        default: ;
      endcase
    end
  end

  assign busy     = state inside {INIT, PROBE, WAIT, DECIDE, BACK, REPLAY};
  assign done     = (state == DONE) || (state == REPLAY);
  assign fail     = (state == FAIL);
  assign path_len = done ? sp : '0;

endmodule

// File: tb/tb_rat_maze_solver_param.sv
// Bench for rat_maze_solver_param: two 4x4 instances (roomy stack and a 4-entry stack) against ROM models.
module tb_rat_maze_solver_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] srow = '0, scol = '0, grow = '0, gcol = '0;
  logic start_a = 1'b0, run_a = 1'b0, start_b = 1'b0, run_b = 1'b0;

  logic [3:0] addr_a, addr_b;
  logic rd_a, rd_b, busy_a, busy_b, done_a, done_b, fail_a, fail_b, mv_a, mv_b;
  logic [1:0] move_a, move_b;
  logic [4:0] len_a;
  logic [2:0] len_b;
  logic wall_a = 1'b0, wall_b = 1'b0;
  logic [15:0] maze_a = '0, maze_b = '0;

  rat_maze_solver_param #(.ROWS(4), .COLS(4), .DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .run(run_a),
    .start_row(srow), .start_col(scol), .goal_row(grow), .goal_col(gcol),
    .mem_addr(addr_a), .mem_rd(rd_a), .mem_wall(wall_a),
    .busy(busy_a), .done(done_a), .fail(fail_a),
    .move(move_a), .move_valid(mv_a), .path_len(len_a)
  );

  rat_maze_solver_param #(.ROWS(4), .COLS(4), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .run(run_b),
    .start_row(srow), .start_col(scol), .goal_row(grow), .goal_col(gcol),
    .mem_addr(addr_b), .mem_rd(rd_b), .mem_wall(wall_b),
    .busy(busy_b), .done(done_b), .fail(fail_b),
    .move(move_b), .move_valid(mv_b), .path_len(len_b)
  );

  // Wall ROMs: one cycle read latency
  always_ff @(posedge clk) begin
    if (rd_a) wall_a <= maze_a[addr_a];
    if (rd_b) wall_b <= maze_b[addr_b];
  end

  int tests = 0;
  int fails = 0;

  typedef struct { logic [1:0] mv; logic cont; } mv_t;
  typedef struct { logic fl; int len; } st_t;
  mv_t mq[$];
  st_t sq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move monitor: every move_valid must match the next queued move; back-to-back where required.
  initial begin
    mv_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mv_a) begin
        if (mq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_move: got %b expected none", move_a);
        end else begin
          e = mq.pop_front();
          chk("move", 32'(move_a), 32'(e.mv));
          if (e.cont) chk("move_consecutive", 32'(prev), 32'd1);
        end
      end
      prev = mv_a;
    end
  end

  // Status monitor: each completion (done or fail rising) is checked against the queued outcome.
  initial begin
    st_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((done_a | fail_a) && !prev) begin
        if (sq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_status: got done=%b fail=%b expected none", done_a, fail_a);
        end else begin
          e = sq.pop_front();
          chk("status_fail", 32'(fail_a), 32'(e.fl));
          chk("status_done", 32'(done_a), 32'(!e.fl));
          chk("path_len", 32'(len_a), 32'(e.len));
        end
      end
      prev = done_a | fail_a;
    end
  end

  task automatic pulse_start(input logic b, input logic [1:0] r0, c0, r1, c1);
    @(posedge clk); #1;
    srow = r0; scol = c0; grow = r1; gcol = c1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic pulse_run();
    @(posedge clk); #1 run_a = 1'b1;
    @(posedge clk); #1 run_a = 1'b0;
  endtask

  task automatic wait_idle(input logic b, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((b ? busy_b : busy_a) && n < 2000);
    if (b ? busy_b : busy_a) begin
      tests++; fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic push_moves(input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) mq.push_back('{mv: seq[2*(n-1-i) +: 2], cont: (i != 0)});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_fail", 32'(fail_a), 0);
    chk("rst_move_valid", 32'(mv_a), 0);
    chk("rst_mem_rd", 32'(rd_a), 0);
    chk("rst_path_len", 32'(len_a), 0);
    rst = 1'b0;

    // 1: open maze, (0,0) -> (0,3): three rights
    maze_a = 16'h0000;
    sq.push_back('{fl: 1'b0, len: 3});
    pulse_start(1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
    wait_idle(1'b0, "t1_search");
    push_moves({10'b0, 2'b01, 2'b01, 2'b01}, 3);
    pulse_run();
    wait_idle(1'b0, "t1_replay");

    // 2: column 1 walled in rows 0-2: D,D,D,R,R,U,U,U
    maze_a = 16'h0222;
    sq.push_back('{fl: 1'b0, len: 8});
    pulse_start(1'b0, 2'd0, 2'd0, 2'd0, 2'd2);
    wait_idle(1'b0, "t2_search");
    push_moves(16'b10_10_10_01_01_00_00_00, 8);
    pulse_run();
    wait_idle(1'b0, "t2_replay");

    // 3: goal (3,3) sealed by walls at (2,3) and (3,2)
    maze_a = 16'h4800;
    sq.push_back('{fl: 1'b1, len: 0});
    pulse_start(1'b0, 2'd0, 2'd0, 2'd3, 2'd3);
    wait_idle(1'b0, "t3_search");
    chk("t3_busy", 32'(busy_a), 0);
    chk("t3_done", 32'(done_a), 0);
    chk("t3_fail", 32'(fail_a), 1);
    pulse_run();
    repeat (4) @(negedge clk);
    chk("t3_fail_after_run", 32'(fail_a), 1);

    // 4: start == goal
    maze_a = 16'h0000;
    sq.push_back('{fl: 1'b0, len: 0});
    pulse_start(1'b0, 2'd2, 2'd2, 2'd2, 2'd2);
    @(posedge clk); #1;
    chk("t4_done_2cyc", 32'(done_a), 1);
    chk("t4_path_len", 32'(len_a), 0);
    pulse_run();
    repeat (4) @(negedge clk);
    chk("t4_busy_after_run", 32'(busy_a), 0);

    // 5: 4-entry stack, serpentine R,R,R,D,D,L overflows on the 5th push
    maze_b = 16'h0070;
    pulse_start(1'b1, 2'd0, 2'd0, 2'd2, 2'd2);
    wait_idle(1'b1, "t5_search");
    chk("t5_fail", 32'(fail_b), 1);
    chk("t5_done", 32'(done_b), 0);
    maze_b = 16'h0000;
    pulse_start(1'b1, 2'd0, 2'd0, 2'd0, 2'd2);
    wait_idle(1'b1, "t5_easy");
    chk("t5_easy_done", 32'(done_b), 1);
    chk("t5_easy_fail", 32'(fail_b), 0);
    chk("t5_easy_len", 32'(len_b), 2);

    // 6: reset on the 2nd replay move, then replay a fresh path twice
    maze_a = 16'h0000;
    sq.push_back('{fl: 1'b0, len: 3});
    pulse_start(1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
    wait_idle(1'b0, "t6_search");
    push_moves({12'b0, 2'b01, 2'b01}, 2);
    pulse_run();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_move_valid", 32'(mv_a), 0);
    chk("t6_rst_done", 32'(done_a), 0);
    rst = 1'b0;
    maze_a = 16'h0222;
    sq.push_back('{fl: 1'b0, len: 8});
    pulse_start(1'b0, 2'd0, 2'd0, 2'd0, 2'd2);
    wait_idle(1'b0, "t6_search2");
    for (int k = 0; k < 2; k++) begin
      push_moves(16'b10_10_10_01_01_00_00_00, 8);
      pulse_run();
      wait_idle(1'b0, "t6_replay");
    end

    repeat (3) @(negedge clk);
    chk("moves_left", 32'(mq.size()), 0);
    chk("status_left", 32'(sq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
